instr_seq_player: RTL

- Program-memory sequencer on the producer side of the experiment FSM's instruction stream.
- CPU preloads a list of instruction words. On start, the block replays the list as an AXI-stream, once or for N passes.
- Raises halt after the final beat so the consumer FSM ends its run on stream-empty.
- Sits between the CPU register bus and the experiment FSM instruction port.

---
 rtl/instr_seq_player.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/instr_seq_player.sv
// Replays a CPU-loaded instruction program as an AXI-stream, once or for N passes,
// then raises halt once every beat has been accepted.
module instr_seq_player #(
   parameter int INSTR_W    = 17,
   parameter int PROG_DEPTH = 1024,
   parameter int ADDR_W     = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               prog_wr_en,
   input  logic [ADDR_W-1:0]  prog_wr_addr,
   input  logic [INSTR_W-1:0] prog_wr_data,
   input  logic [ADDR_W:0]    prog_len,
   input  logic [15:0]        loop_count,
   input  logic               start,
   input  logic               abort,
   output logic [INSTR_W-1:0] instr_axis_tdata,
   output logic               instr_axis_tvalid,
   input  logic               instr_axis_tready,
   output logic               halt,
   output logic               busy,
   output logic [15:0]        pass_cnt,
   output logic               cfg_err
);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(PROG_DEPTH);

   logic [INSTR_W-1:0] mem [PROG_DEPTH];

   state_t             state_q, state_d;
   logic [INSTR_W-1:0] rd_data_q;
   logic               rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
   logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
   logic [ADDR_W:0]    len_q, len_d;
   logic [15:0]        loops_q, loops_d, iss_pass_q, iss_pass_d;
   logic               out_vld_q, out_vld_d, out_last_q, out_last_d;
   logic [INSTR_W-1:0] out_data_q, out_data_d;
   logic               skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
   logic [INSTR_W-1:0] skid_data_q, skid_data_d;
   logic [15:0]        pass_q, pass_d;
   logic               halt_q, halt_d, cfg_err_q, cfg_err_d;
   logic               rd_en, pop, last_addr, len_ok;
   logic [1:0]         occ;

   always_comb begin
      state_d     = state_q;
      rd_en       = 1'b0;
      rd_vld_d    = 1'b0;
      rd_last_d   = rd_last_q;
      rd_addr_d   = rd_addr_q;
      len_d       = len_q;
      loops_d     = loops_q;
      iss_pass_d  = iss_pass_q;
      out_vld_d   = out_vld_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      skid_last_d = skid_last_q;
      pass_d      = pass_q;
      halt_d      = halt_q;
      cfg_err_d   = cfg_err_q;

      pop       = out_vld_q & instr_axis_tready;
      occ       = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(rd_vld_q);
      last_addr = ({1'b0, rd_addr_q} == (len_q - 1'b1));
      len_ok    = (prog_len != '0) && (prog_len <= DEPTH_L);

      // RAM output lands in the output register when it is free, otherwise in the skid entry
      if (!out_vld_q || pop) begin
         if (skid_vld_q) begin
            out_vld_d   = 1'b1;
            out_data_d  = skid_data_q;
            out_last_d  = skid_last_q;
            skid_vld_d  = rd_vld_q;
            skid_data_d = rd_data_q;
            skid_last_d = rd_last_q;
         end else begin
            out_vld_d = rd_vld_q;
            if (rd_vld_q) begin
               out_data_d = rd_data_q;
               out_last_d = rd_last_q;
            end
         end
      end else if (rd_vld_q) begin
         skid_vld_d  = 1'b1;
         skid_data_d = rd_data_q;
         skid_last_d = rd_last_q;
      end

      if (pop && out_last_q && (pass_q != '1)) pass_d = pass_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (len_ok) begin
                  len_d      = prog_len;
                  loops_d    = loop_count;
                  pass_d     = '0;
                  rd_addr_d  = '0;
                  iss_pass_d = '0;
                  cfg_err_d  = 1'b0;
                  state_d    = STREAM;
               end else begin
                  cfg_err_d = 1'b1;
                  halt_d    = 1'b1;
                  state_d   = DONE;
               end
            end
         end
         STREAM, DRAIN: begin
            if (abort) begin
               out_vld_d  = 1'b0;
               skid_vld_d = 1'b0;
               halt_d     = 1'b1;
               state_d    = DONE;
            end else if (state_q == STREAM) begin
               // a read is issued only if its word is sure to find a free slot next cycle
               if (occ <= 2'(pop) + 2'd1) begin
                  rd_en     = 1'b1;
                  rd_vld_d  = 1'b1;
                  rd_last_d = last_addr;
                  rd_addr_d = last_addr ? '0 : rd_addr_q + 1'b1;
                  if (last_addr) begin
                     if (iss_pass_q != '1) iss_pass_d = iss_pass_q + 1'b1;
                     if ((loops_q != '0) && (16'(iss_pass_q + 1'b1) == loops_q)) state_d = DRAIN;
                  end
               end
            end else if (!out_vld_d && !skid_vld_d) begin
               halt_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (!start) begin
               halt_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if ((state_q == IDLE) && prog_wr_en) mem[prog_wr_addr] <= prog_wr_data;
      if (rd_en) rd_data_q <= mem[rd_addr_q];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         rd_vld_q    <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_addr_q   <= '0;
         len_q       <= '0;
         loops_q     <= '0;
         iss_pass_q  <= '0;
         out_vld_q   <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         skid_vld_q  <= 1'b0;
         skid_data_q <= '0;
         skid_last_q <= 1'b0;
         pass_q      <= '0;
         halt_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_vld_q    <= rd_vld_d;
         rd_last_q   <= rd_last_d;
         rd_addr_q   <= rd_addr_d;
         len_q       <= len_d;
         loops_q     <= loops_d;
         iss_pass_q  <= iss_pass_d;
         out_vld_q   <= out_vld_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         skid_vld_q  <= skid_vld_d;
         skid_data_q <= skid_data_d;
         skid_last_q <= skid_last_d;
         pass_q      <= pass_d;
         halt_q      <= halt_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign instr_axis_tdata  = out_data_q;
   assign instr_axis_tvalid = out_vld_q;
   assign halt              = halt_q;
   assign busy              = (state_q != IDLE);
   assign pass_cnt          = pass_q;
   assign cfg_err           = cfg_err_q;

endmodule
